// File: rtl/alu_rs.sv
// alu_rs - reservation station in front of the ALU.
//
// Holds up to 2**RS_SIZE_WIDTH decoded ALU instructions. Operands that are
// still being produced are tracked by ROB tag and captured from either of two
// CDB ports. Each cycle the lowest-index entry with both operands available
// is issued over a registered ready/op/val_1/val_2/rob_id interface.
//
// Optional feature macro: ALU_RS_WAKEUP_BYPASS_EN
//   defined   - select also sees operands arriving on the CDB this cycle, so
//               wakeup-to-issue is one edge and the value comes straight from
//               the CDB.
//   undefined - select uses registered operand state only (two edges).
//
// XLEN and ALU_OP_WIDTH normally come from global_params.v; defaults are
// provided here so the file stands on its own.
//
// Ports:
//   clk, rst (sync, active-high), flush (sync, clears all entries)
//   dec_*        dispatch request and decoded instruction fields
//   full         every entry busy; dispatch must hold off
//   cdb0_*       CDB broadcast from the ALU (priority port)
//   cdb1_*       CDB broadcast from the LSB
//   alu_ready    registered issue valid; alu_op/val_1/val_2/rob_id are 0
//                whenever alu_ready is 0

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module alu_rs #(
    parameter int RS_SIZE_WIDTH = 3,
    parameter int ROB_TAG_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     dec_valid,
    input  logic [`ALU_OP_WIDTH-1:0] dec_op,
    input  logic                     dec_qj_valid,
    input  logic                     dec_qk_valid,
    input  logic [ROB_TAG_WIDTH-1:0] dec_qj,
    input  logic [ROB_TAG_WIDTH-1:0] dec_qk,
    input  logic [`XLEN-1:0]         dec_vj,
    input  logic [`XLEN-1:0]         dec_vk,
    input  logic [ROB_TAG_WIDTH-1:0] dec_rob_id,
    output logic                     full,
    input  logic                     cdb0_valid,
    input  logic [ROB_TAG_WIDTH-1:0] cdb0_rob_id,
    input  logic [`XLEN-1:0]         cdb0_value,
    input  logic                     cdb1_valid,
    input  logic [ROB_TAG_WIDTH-1:0] cdb1_rob_id,
    input  logic [`XLEN-1:0]         cdb1_value,
    output logic                     alu_ready,
    output logic [`ALU_OP_WIDTH-1:0] alu_op,
    output logic [`XLEN-1:0]         alu_val_1,
    output logic [`XLEN-1:0]         alu_val_2,
    output logic [ROB_TAG_WIDTH-1:0] alu_rob_id
);

    localparam int N  = 1 << RS_SIZE_WIDTH;
    localparam int IW = RS_SIZE_WIDTH;
    localparam int TW = ROB_TAG_WIDTH;
    localparam int XW = `XLEN;
    localparam int OW = `ALU_OP_WIDTH;

    // Entry storage
    logic [N-1:0]  busy_q, busy_d;
    logic [N-1:0]  qjv_q, qjv_d, qkv_q, qkv_d;
    logic [OW-1:0] op_q  [N];
    logic [OW-1:0] op_d  [N];
    logic [XW-1:0] vj_q  [N];
    logic [XW-1:0] vj_d  [N];
    logic [XW-1:0] vk_q  [N];
    logic [XW-1:0] vk_d  [N];
    logic [TW-1:0] qj_q  [N];
    logic [TW-1:0] qj_d  [N];
    logic [TW-1:0] qk_q  [N];
    logic [TW-1:0] qk_d  [N];
    logic [TW-1:0] rob_q [N];
    logic [TW-1:0] rob_d [N];

    // Issue registers
    logic          alu_ready_q;
    logic [OW-1:0] alu_op_q;
    logic [XW-1:0] alu_val_1_q, alu_val_2_q;
    logic [TW-1:0] alu_rob_id_q;

    // Operand state after this cycle's CDB snoop
    logic [N-1:0]  wake_qjv, wake_qkv;
    logic [XW-1:0] wake_vj [N];
    logic [XW-1:0] wake_vk [N];
    logic          cap_qjv, cap_qkv;
    logic [XW-1:0] cap_vj, cap_vk;

    logic [N-1:0]  elig;
    logic          sel_found, alloc_found;
    logic [IW-1:0] sel_idx, alloc_idx;
    logic          do_alloc;

    // Returns {still_pending, value}; cdb0 wins when both ports match.
    function automatic logic [XW:0] snoop(
        input logic          pend,
        input logic [TW-1:0] tag,
        input logic [XW-1:0] val,
        input logic          c0v,
        input logic [TW-1:0] c0t,
        input logic [XW-1:0] c0d,
        input logic          c1v,
        input logic [TW-1:0] c1t,
        input logic [XW-1:0] c1d
    );
        logic [XW:0] r;
        r = {pend, val};
        if (pend) begin
            if (c0v && (c0t == tag))      r = {1'b0, c0d};
            else if (c1v && (c1t == tag)) r = {1'b0, c1d};
        end
        return r;
    endfunction

    // Returns {found, index of lowest set bit}.
    function automatic logic [IW:0] lowest(input logic [N-1:0] v);
        logic [IW:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = {1'b1, IW'(i)};
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            {wake_qjv[i], wake_vj[i]} = snoop(qjv_q[i], qj_q[i], vj_q[i],
                cdb0_valid, cdb0_rob_id, cdb0_value, cdb1_valid, cdb1_rob_id, cdb1_value);
            {wake_qkv[i], wake_vk[i]} = snoop(qkv_q[i], qk_q[i], vk_q[i],
                cdb0_valid, cdb0_rob_id, cdb0_value, cdb1_valid, cdb1_rob_id, cdb1_value);
        end
        {cap_qjv, cap_vj} = snoop(dec_qj_valid, dec_qj, dec_vj,
            cdb0_valid, cdb0_rob_id, cdb0_value, cdb1_valid, cdb1_rob_id, cdb1_value);
        {cap_qkv, cap_vk} = snoop(dec_qk_valid, dec_qk, dec_vk,
            cdb0_valid, cdb0_rob_id, cdb0_value, cdb1_valid, cdb1_rob_id, cdb1_value);
    end

    // Both selection rules use busy_q, so an entry is never issued in the
    // cycle it is dispatched. Once an operand is registered as ready its
    // wake_* value equals the stored value, so issue always reads wake_*.
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    assign elig = busy_q & ~wake_qjv & ~wake_qkv;
`else
    assign elig = busy_q & ~qjv_q & ~qkv_q;
`endif

    assign full                     = &busy_q;
    assign {sel_found, sel_idx}     = lowest(elig);
    assign {alloc_found, alloc_idx} = lowest(~busy_q);
    assign do_alloc                 = dec_valid && !full && alloc_found;

    always_comb begin
        busy_d = busy_q;
        qjv_d  = wake_qjv;
        qkv_d  = wake_qkv;
        op_d   = op_q;
        vj_d   = wake_vj;
        vk_d   = wake_vk;
        qj_d   = qj_q;
        qk_d   = qk_q;
        rob_d  = rob_q;
        if (sel_found) busy_d[sel_idx] = 1'b0;
        // The allocated slot was free, so it never collides with the issued one.
        if (do_alloc) begin
            busy_d[alloc_idx] = 1'b1;
            op_d[alloc_idx]   = dec_op;
            qjv_d[alloc_idx]  = cap_qjv;
            qkv_d[alloc_idx]  = cap_qkv;
            vj_d[alloc_idx]   = cap_vj;
            vk_d[alloc_idx]   = cap_vk;
            qj_d[alloc_idx]   = dec_qj;
            qk_d[alloc_idx]   = dec_qk;
            rob_d[alloc_idx]  = dec_rob_id;
        end
        if (flush) busy_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // Payload of free entries is don't-care, so it carries no reset.
    always_ff @(posedge clk) begin
        qjv_q <= qjv_d;
        qkv_q <= qkv_d;
        op_q  <= op_d;
        vj_q  <= vj_d;
        vk_q  <= vk_d;
        qj_q  <= qj_d;
        qk_q  <= qk_d;
        rob_q <= rob_d;
    end

    always_ff @(posedge clk) begin
        if (rst || flush || !sel_found) begin
            alu_ready_q  <= 1'b0;
            alu_op_q     <= '0;
            alu_val_1_q  <= '0;
            alu_val_2_q  <= '0;
            alu_rob_id_q <= '0;
        end else begin
            alu_ready_q  <= 1'b1;
            alu_op_q     <= op_q[sel_idx];
            alu_val_1_q  <= wake_vj[sel_idx];
            alu_val_2_q  <= wake_vk[sel_idx];
            alu_rob_id_q <= rob_q[sel_idx];
        end
    end

    assign alu_ready  = alu_ready_q;
    assign alu_op     = alu_op_q;
    assign alu_val_1  = alu_val_1_q;
    assign alu_val_2  = alu_val_2_q;
    assign alu_rob_id = alu_rob_id_q;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: a per-cycle vector table (inputs before an edge,
// expected registered outputs after it) plus a hand-written fill/drain run.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module tb_alu_rs;

    localparam int XW   = `XLEN;
    localparam int OPW  = `ALU_OP_WIDTH;
    localparam int OUTW = 1 + OPW + 2 * XW + 3 + 1;
    localparam logic [OPW-1:0] ADD = OPW'(1);
    localparam logic [OPW-1:0] SUB = OPW'(2);

    logic           clk = 1'b0;
    logic           rst, flush, dec_valid;
    logic [OPW-1:0] dec_op;
    logic           dec_qj_valid, dec_qk_valid;
    logic [2:0]     dec_qj, dec_qk, dec_rob_id;
    logic [XW-1:0]  dec_vj, dec_vk;
    logic           full;
    logic           cdb0_valid, cdb1_valid;
    logic [2:0]     cdb0_rob_id, cdb1_rob_id;
    logic [XW-1:0]  cdb0_value, cdb1_value;
    logic           alu_ready;
    logic [OPW-1:0] alu_op;
    logic [XW-1:0]  alu_val_1, alu_val_2;
    logic [2:0]     alu_rob_id;

    int tests  = 0;
    int failed = 0;

    alu_rs #(.RS_SIZE_WIDTH(3), .ROB_TAG_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dec_valid(dec_valid), .dec_op(dec_op),
        .dec_qj_valid(dec_qj_valid), .dec_qk_valid(dec_qk_valid),
        .dec_qj(dec_qj), .dec_qk(dec_qk), .dec_vj(dec_vj), .dec_vk(dec_vk),
        .dec_rob_id(dec_rob_id), .full(full),
        .cdb0_valid(cdb0_valid), .cdb0_rob_id(cdb0_rob_id), .cdb0_value(cdb0_value),
        .cdb1_valid(cdb1_valid), .cdb1_rob_id(cdb1_rob_id), .cdb1_value(cdb1_value),
        .alu_ready(alu_ready), .alu_op(alu_op), .alu_val_1(alu_val_1),
        .alu_val_2(alu_val_2), .alu_rob_id(alu_rob_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            rst;
        logic            flush;
        logic            dv;
        logic [OPW-1:0]  op;
        logic            qjv;
        logic [2:0]      qj;
        logic [XW-1:0]   vj;
        logic            qkv;
        logic [2:0]      qk;
        logic [XW-1:0]   vk;
        logic [2:0]      rob;
        logic            c0v;
        logic [2:0]      c0id;
        logic [XW-1:0]   c0val;
        logic            c1v;
        logic [2:0]      c1id;
        logic [XW-1:0]   c1val;
        logic [OUTW-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t nop();
        vec_t r;
        r = '0;
        return r;
    endfunction

    function automatic vec_t D(input logic [OPW-1:0] op, input logic qjv, input logic [2:0] qj,
                               input logic [XW-1:0] vj, input logic qkv, input logic [2:0] qk,
                               input logic [XW-1:0] vk, input logic [2:0] rob);
        vec_t r;
        r = '0;
        r.dv = 1'b1; r.op = op; r.qjv = qjv; r.qj = qj; r.vj = vj;
        r.qkv = qkv; r.qk = qk; r.vk = vk; r.rob = rob;
        return r;
    endfunction

    function automatic vec_t C0(input vec_t r0, input logic [2:0] id, input logic [XW-1:0] val);
        vec_t r;
        r = r0; r.c0v = 1'b1; r.c0id = id; r.c0val = val;
        return r;
    endfunction

    function automatic vec_t C1(input vec_t r0, input logic [2:0] id, input logic [XW-1:0] val);
        vec_t r;
        r = r0; r.c1v = 1'b1; r.c1id = id; r.c1val = val;
        return r;
    endfunction

    function automatic logic [OUTW-1:0] X(input logic rdy, input logic [OPW-1:0] op,
                                          input logic [XW-1:0] v1, input logic [XW-1:0] v2,
                                          input logic [2:0] rob, input logic f);
        return {rdy, op, v1, v2, rob, f};
    endfunction

    function automatic vec_t E(input vec_t r0, input logic [OUTW-1:0] e);
        vec_t r;
        r = r0; r.exp = e;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        rst = r.rst; flush = r.flush; dec_valid = r.dv; dec_op = r.op;
        dec_qj_valid = r.qjv; dec_qj = r.qj; dec_vj = r.vj;
        dec_qk_valid = r.qkv; dec_qk = r.qk; dec_vk = r.vk; dec_rob_id = r.rob;
        cdb0_valid = r.c0v; cdb0_rob_id = r.c0id; cdb0_value = r.c0val;
        cdb1_valid = r.c1v; cdb1_rob_id = r.c1id; cdb1_value = r.c1val;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [OUTW-1:0] want);
        logic [OUTW-1:0] got;
        got = {alu_ready, alu_op, alu_val_1, alu_val_2, alu_rob_id, full};
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got {rdy,op,v1,v2,rob,full}=%h expected %h", name, got, want);
        end
    endtask

    localparam logic [OUTW-1:0] Z = '0;

    initial begin
        vec_t r;

        // Reset, then a ready-operand dispatch issues after two edges.
        r = nop(); r.rst = 1'b1;
        vecs.push_back(E(r, Z));
        vecs.push_back(E(D(ADD, 0, 0, 3, 0, 0, 4, 2), Z));
        vecs.push_back(E(nop(), X(1, ADD, 3, 4, 2, 0)));
        vecs.push_back(E(nop(), Z));
        // Wakeup through cdb1; tag 6 on cdb0 must not wake it.
        vecs.push_back(E(D(SUB, 1, 5, 0, 0, 0, 1, 1), Z));
        vecs.push_back(E(C0(nop(), 6, 99), Z));
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        vecs.push_back(E(C1(nop(), 5, 10), X(1, SUB, 10, 1, 1, 0)));
        vecs.push_back(E(nop(), Z));
`else
        vecs.push_back(E(C1(nop(), 5, 10), Z));
        vecs.push_back(E(nop(), X(1, SUB, 10, 1, 1, 0)));
`endif
        vecs.push_back(E(nop(), Z));
        // Same-cycle capture at dispatch.
        vecs.push_back(E(C0(D(ADD, 1, 4, 0, 0, 0, 5, 3), 4, 'hFF), Z));
        vecs.push_back(E(nop(), X(1, ADD, 'hFF, 5, 3, 0)));
        vecs.push_back(E(nop(), Z));
        // Both operands captured at dispatch, both CDBs match: cdb0 wins.
        vecs.push_back(E(C1(C0(D(SUB, 1, 4, 0, 1, 4, 0, 5), 4, 'h11), 4, 'h22), Z));
        vecs.push_back(E(nop(), X(1, SUB, 'h11, 'h11, 5, 0)));
        vecs.push_back(E(nop(), Z));
        // Priority: entries 1 and 3 wake together, 0 and 2 stay pending.
        vecs.push_back(E(D(ADD, 1, 6, 0, 0, 0, 0, 0), Z));
        vecs.push_back(E(D(ADD, 1, 5, 0, 0, 0, 7, 1), Z));
        vecs.push_back(E(D(ADD, 1, 6, 0, 0, 0, 0, 2), Z));
        vecs.push_back(E(D(SUB, 1, 5, 0, 0, 0, 8, 3), Z));
`ifdef ALU_RS_WAKEUP_BYPASS_EN
        vecs.push_back(E(C0(nop(), 5, 20), X(1, ADD, 20, 7, 1, 0)));
        vecs.push_back(E(nop(), X(1, SUB, 20, 8, 3, 0)));
        vecs.push_back(E(nop(), Z));
`else
        vecs.push_back(E(C0(nop(), 5, 20), Z));
        vecs.push_back(E(nop(), X(1, ADD, 20, 7, 1, 0)));
        vecs.push_back(E(nop(), X(1, SUB, 20, 8, 3, 0)));
`endif
        vecs.push_back(E(nop(), Z));
        // Flush with four busy entries and a simultaneous dispatch.
        vecs.push_back(E(D(ADD, 1, 6, 0, 0, 0, 0, 4), Z));
        vecs.push_back(E(D(ADD, 1, 6, 0, 0, 0, 0, 5), Z));
        r = D(ADD, 0, 0, 1, 0, 0, 1, 6); r.flush = 1'b1;
        vecs.push_back(E(r, Z));
        vecs.push_back(E(C0(nop(), 6, 1), Z));
        vecs.push_back(E(nop(), Z));
        vecs.push_back(E(nop(), Z));
        // Reset mid-stream drops a ready entry; dispatch accepted right after.
        vecs.push_back(E(D(ADD, 0, 0, 9, 0, 0, 9, 7), Z));
        r = nop(); r.rst = 1'b1;
        vecs.push_back(E(r, Z));
        vecs.push_back(E(D(ADD, 0, 0, 2, 0, 0, 3, 1), Z));
        vecs.push_back(E(nop(), X(1, ADD, 2, 3, 1, 0)));
        vecs.push_back(E(nop(), Z));

        drive(nop());
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k]);
            step();
            check($sformatf("vec%0d", k), vecs[k].exp);
        end

        // Fill all eight entries pending on tag 7.
        for (int i = 0; i < 8; i++) begin
            drive(D(ADD, 1, 7, 0, 0, 0, XW'(i), 3'(i)));
            step();
            check($sformatf("fill%0d", i), X(0, 0, 0, 0, 0, (i == 7)));
        end
        // Ninth dispatch while full must be ignored.
        drive(D(SUB, 0, 0, 'h99, 0, 0, 'h99, 0));
        step();
        check("full_ignore", X(0, 0, 0, 0, 0, 1));
        drive(C0(nop(), 7, 'h70));
        step();
        drive(nop());
`ifndef ALU_RS_WAKEUP_BYPASS_EN
        check("fill_wake", X(0, 0, 0, 0, 0, 1));
        step();
`endif
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d", i), X(1, ADD, 'h70, XW'(i), 3'(i), 0));
            step();
        end
        check("drain_end", Z);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
